rotate_seq: RTL

// Multi-cycle shift/rotate sequencer for the 20-bit ALU datapath. Applies the

---
 rtl/rotate_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rotate_seq.sv
// Multi-cycle shift/rotate sequencer for the 20-bit ALU datapath.
// Performs ROL/ROR/SHL/SHR by 0..31 positions, one single-bit step per clock.
module rotate_seq #(
  parameter int WIDTH = 20,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       OP_ROL     = 2'b00;
  localparam logic [1:0]       OP_ROR     = 2'b01;
  localparam logic [1:0]       OP_SHL     = 2'b10;
  localparam logic [1:0]       OP_SHR     = 2'b11;
  localparam logic [AMT_W-1:0] WIDTH_AMT  = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] CNT_ZERO   = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] CNT_ONE    = AMT_W'(1);
  localparam logic [WIDTH-1:0] DATA_ZERO  = {WIDTH{1'b0}};

  // Rotates wrap modulo WIDTH; shifts saturate at WIDTH (everything shifted out).
  function automatic logic [AMT_W-1:0] eff_count(input logic [AMT_W-1:0] amt,
                                                 input logic [1:0]       op);
    logic [AMT_W-1:0] n;
    n = amt;
    case (op)
      OP_ROL, OP_ROR: begin
        if (amt >= WIDTH_AMT) n = amt - WIDTH_AMT;
        else                  n = amt;
      end
      OP_SHL, OP_SHR: begin
        if (amt > WIDTH_AMT) n = WIDTH_AMT;
        else                 n = amt;
      end
      default: n = amt;
    endcase
    return n;
  endfunction

  // One single-bit step; result is {carry_out, new_data}.
  function automatic logic [WIDTH:0] step_one(input logic [WIDTH-1:0] d,
                                              input logic [1:0]       op);
    logic [WIDTH:0] r;
    r = {1'b0, d};
    case (op)
      OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      OP_SHR:  r = {d[0], 1'b0, d[WIDTH-1:1]};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AMT_W-1:0] cnt_r;
  logic [WIDTH-1:0] work_data_r;
  logic             work_carry_r;
  logic [1:0]       op_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_carry_r;
  logic             in_ready_s;
  logic             busy_s;
  logic             accept_s;
  logic             release_s;
  logic [AMT_W-1:0] eff_cnt_s;
  logic [WIDTH:0]   step_s;

  assign eff_cnt_s = eff_count(in_amt, in_op);
  assign step_s    = step_one(work_data_r, op_r);
  assign accept_s  = in_valid && in_ready_s;
  assign release_s = out_valid_r && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (eff_cnt_s == CNT_ZERO) state_nxt_s = ST_DONE;
          else                       state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_ONE) state_nxt_s = ST_DONE;
        else                  state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (release_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State-decoded handshake/status outputs.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b1;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      ST_RUN: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
      end
      ST_DONE: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
      end
    endcase
  end

  // Working registers: load on accept, step once per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= CNT_ZERO;
      work_data_r  <= DATA_ZERO;
      work_carry_r <= 1'b0;
      op_r         <= OP_ROL;
    end else if (accept_s) begin
      cnt_r        <= eff_cnt_s;
      work_data_r  <= in_data;
      work_carry_r <= 1'b0;
      op_r         <= in_op;
    end else if (state_r == ST_RUN) begin
      cnt_r        <= cnt_r - CNT_ONE;
      work_data_r  <= step_s[WIDTH-1:0];
      work_carry_r <= step_s[WIDTH];
    end else begin
      cnt_r        <= cnt_r;
      work_data_r  <= work_data_r;
      work_carry_r <= work_carry_r;
      op_r         <= op_r;
    end
  end

  // Result stage: captures the finished result one cycle after DONE is
  // entered and freezes it until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_ZERO;
      out_carry_r <= 1'b0;
    end else if (release_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_carry_r <= out_carry_r;
    end else if ((state_r == ST_DONE) && !out_valid_r) begin
      out_valid_r <= 1'b1;
      out_data_r  <= work_data_r;
      out_carry_r <= work_carry_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_carry_r <= out_carry_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = busy_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_carry = out_carry_r;
  assign out_zero  = (out_data_r == DATA_ZERO);

endmodule
